// File: rtl/rr_trace_buf_sequencer.sv
// rtl/rr_trace_buf_sequencer.sv - host-buffer sequencer for the trace writer window
//
// Queues software-posted buffer descriptors and programs the next one into the
// writer's window when the writer reports the current window exhausted. Each
// closed buffer produces a completion record {addr, recorded bits, cycle}.
//
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   desc_valid/ready/addr/size     descriptor post (ready is registered ~full)
//   write_buf_addr/size/update     writer window programming, 1-cycle update pulse
//   write_interrupt, record_bits   writer status: window exhausted, bits consumed
//   done_valid/ready/addr/bits/cycle  completion record queue (first-word-fall-through)
//   starve_cycles                  saturating count of exhausted cycles with no descriptor
//   bad_desc                       sticky: a zero-size or misaligned-size descriptor was dropped
//
// Configuration macro: RR_BUFSEQ_TIMESTAMP_EN enables a 64-bit cycle counter whose
// value at buffer close is stored per completion entry; otherwise done_cycle is 0.

module rr_trace_buf_sequencer #(
    parameter int AXI_ADDR_WIDTH = 64,
    parameter int AXI_WIDTH      = 512,
    parameter int DESC_DEPTH     = 4,
    parameter int DONE_DEPTH     = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      desc_valid,
    output logic                      desc_ready,
    input  logic [AXI_ADDR_WIDTH-1:0] desc_addr,
    input  logic [AXI_ADDR_WIDTH-1:0] desc_size,
    output logic [AXI_ADDR_WIDTH-1:0] write_buf_addr,
    output logic [AXI_ADDR_WIDTH-1:0] write_buf_size,
    output logic                      write_buf_update,
    input  logic                      write_interrupt,
    input  logic [63:0]               record_bits,
    output logic                      done_valid,
    input  logic                      done_ready,
    output logic [AXI_ADDR_WIDTH-1:0] done_addr,
    output logic [63:0]               done_bits,
    output logic [63:0]               done_cycle,
    output logic [31:0]               starve_cycles,
    output logic                      bad_desc
);

    localparam int DP_W = $clog2(DESC_DEPTH);
    localparam int DN_W = $clog2(DONE_DEPTH);

    localparam logic [AXI_ADDR_WIDTH-1:0] BEAT_MASK = AXI_ADDR_WIDTH'(AXI_WIDTH / 8 - 1);
    localparam logic [DP_W-1:0] DP_ONE   = 1;
    localparam logic [DP_W:0]   DC_ONE   = 1;
    localparam logic [DP_W:0]   DC_FULL  = (DP_W + 1)'(DESC_DEPTH);
    localparam logic [DN_W-1:0] DN_ONE   = 1;
    localparam logic [DN_W:0]   NC_ONE   = 1;
    localparam logic [DN_W:0]   NC_FULL  = (DN_W + 1)'(DONE_DEPTH);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD   = 3'd1;
    localparam logic [2:0] ST_SETTLE = 3'd2;
    localparam logic [2:0] ST_ACTIVE = 3'd3;
    localparam logic [2:0] ST_CLOSE  = 3'd4;
    localparam logic [2:0] ST_WAIT   = 3'd5;

    logic [2:0] state_q, state_d;
    logic       settle_q, settle_d;

    // Descriptor queue
    logic [AXI_ADDR_WIDTH-1:0] desc_addr_mem [DESC_DEPTH];
    logic [AXI_ADDR_WIDTH-1:0] desc_size_mem [DESC_DEPTH];
    logic [DP_W-1:0]           desc_wr_q, desc_rd_q;
    logic [DP_W:0]             desc_cnt_q, desc_cnt_d;
    logic                      desc_ready_q;
    logic                      desc_fire, desc_size_ok, desc_push, desc_pop, desc_nonempty;

    // Completion queue
    logic [AXI_ADDR_WIDTH-1:0] done_addr_mem [DONE_DEPTH];
    logic [63:0]               done_bits_mem [DONE_DEPTH];
    logic [DN_W-1:0]           done_wr_q, done_rd_q;
    logic [DN_W:0]             done_cnt_q;
    logic                      done_full, done_push, done_pop;

    // write_buf_addr_q doubles as the address of the buffer currently being filled.
    logic [AXI_ADDR_WIDTH-1:0] write_buf_addr_q, write_buf_size_q;
    logic                      write_buf_update_q;
    logic [31:0]               starve_q;
    logic                      bad_desc_q;

    assign desc_fire     = desc_valid & desc_ready_q;
    assign desc_size_ok  = (desc_size != '0) && ((desc_size & BEAT_MASK) == '0);
    assign desc_push     = desc_fire & desc_size_ok;
    assign desc_nonempty = (desc_cnt_q != '0);
    // The head is consumed on the edge that enters LOAD, so the window registers
    // and the update pulse are both visible during the LOAD cycle.
    assign desc_pop      = (state_d == ST_LOAD);

    assign done_full  = (done_cnt_q == NC_FULL);
    assign done_valid = (done_cnt_q != '0);
    assign done_push  = (state_q == ST_CLOSE) & ~done_full;
    assign done_pop   = done_valid & done_ready;

    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        case (state_q)
            ST_IDLE:   if (desc_nonempty) state_d = ST_LOAD;
            ST_LOAD: begin
                state_d  = ST_SETTLE;
                settle_d = 1'b0;
            end
            // The writer's interrupt is stale right after an update; wait two cycles.
            ST_SETTLE: begin
                settle_d = 1'b1;
                if (settle_q) state_d = ST_ACTIVE;
            end
            ST_ACTIVE: if (write_interrupt) state_d = ST_CLOSE;
            // Holding here while the done queue is full is safe: the writer stays
            // exhausted and record_bits stays frozen until the next update.
            ST_CLOSE: begin
                if (!done_full) state_d = desc_nonempty ? ST_LOAD : ST_WAIT;
            end
            ST_WAIT:   if (desc_nonempty) state_d = ST_LOAD;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        desc_cnt_d = desc_cnt_q;
        if (desc_push && !desc_pop) begin
            desc_cnt_d = desc_cnt_q + DC_ONE;
        end else if (!desc_push && desc_pop) begin
            desc_cnt_d = desc_cnt_q - DC_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (desc_push) begin
            desc_addr_mem[desc_wr_q] <= desc_addr;
            desc_size_mem[desc_wr_q] <= desc_size;
        end
        if (done_push) begin
            done_addr_mem[done_wr_q] <= write_buf_addr_q;
            done_bits_mem[done_wr_q] <= record_bits;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q            <= ST_IDLE;
            settle_q           <= 1'b0;
            desc_wr_q          <= '0;
            desc_rd_q          <= '0;
            desc_cnt_q         <= '0;
            desc_ready_q       <= 1'b0;
            done_wr_q          <= '0;
            done_rd_q          <= '0;
            done_cnt_q         <= '0;
            write_buf_addr_q   <= '0;
            write_buf_size_q   <= '0;
            write_buf_update_q <= 1'b0;
            starve_q           <= '0;
            bad_desc_q         <= 1'b0;
        end else begin
            state_q    <= state_d;
            settle_q   <= settle_d;
            desc_cnt_q <= desc_cnt_d;
            // Registered ready reflects next-cycle occupancy, so it is never optimistic.
            desc_ready_q <= (desc_cnt_d != DC_FULL);
            if (desc_push) desc_wr_q <= desc_wr_q + DP_ONE;
            if (desc_pop)  desc_rd_q <= desc_rd_q + DP_ONE;

            if (done_push) done_wr_q <= done_wr_q + DN_ONE;
            if (done_pop)  done_rd_q <= done_rd_q + DN_ONE;
            if (done_push && !done_pop) begin
                done_cnt_q <= done_cnt_q + NC_ONE;
            end else if (!done_push && done_pop) begin
                done_cnt_q <= done_cnt_q - NC_ONE;
            end

            write_buf_update_q <= desc_pop;
            if (desc_pop) begin
                write_buf_addr_q <= desc_addr_mem[desc_rd_q];
                write_buf_size_q <= desc_size_mem[desc_rd_q];
            end

            if (state_q == ST_WAIT && !desc_nonempty && starve_q != '1) begin
                starve_q <= starve_q + 32'd1;
            end
            if (desc_fire && !desc_size_ok) bad_desc_q <= 1'b1;
        end
    end

`ifdef RR_BUFSEQ_TIMESTAMP_EN
    logic [63:0] cycle_q;
    logic [63:0] done_cycle_mem [DONE_DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_q <= '0;
        end else begin
            cycle_q <= cycle_q + 64'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (done_push) done_cycle_mem[done_wr_q] <= cycle_q;
    end

    assign done_cycle = done_valid ? done_cycle_mem[done_rd_q] : 64'd0;
`else
    assign done_cycle = 64'd0;
`endif

    // Outputs read zero while the completion queue is empty.
    assign done_addr        = done_valid ? done_addr_mem[done_rd_q] : '0;
    assign done_bits        = done_valid ? done_bits_mem[done_rd_q] : 64'd0;
    assign desc_ready       = desc_ready_q;
    assign write_buf_addr   = write_buf_addr_q;
    assign write_buf_size   = write_buf_size_q;
    assign write_buf_update = write_buf_update_q;
    assign starve_cycles    = starve_q;
    assign bad_desc         = bad_desc_q;

endmodule

// File: tb/tb_rr_trace_buf_sequencer.sv
// tb/tb_rr_trace_buf_sequencer.sv - scoreboard bench for rr_trace_buf_sequencer
module tb_rr_trace_buf_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        desc_valid = 1'b0;
    logic        desc_ready;
    logic [63:0] desc_addr = '0;
    logic [63:0] desc_size = '0;
    logic [63:0] write_buf_addr, write_buf_size;
    logic        write_buf_update;
    logic        write_interrupt = 1'b0;
    logic [63:0] record_bits = '0;
    logic        done_valid;
    logic        done_ready = 1'b1;
    logic [63:0] done_addr, done_bits, done_cycle;
    logic [31:0] starve_cycles;
    logic        bad_desc;

    always #5 clk = ~clk;

    rr_trace_buf_sequencer dut (
        .clk(clk), .rst(rst),
        .desc_valid(desc_valid), .desc_ready(desc_ready),
        .desc_addr(desc_addr), .desc_size(desc_size),
        .write_buf_addr(write_buf_addr), .write_buf_size(write_buf_size),
        .write_buf_update(write_buf_update),
        .write_interrupt(write_interrupt), .record_bits(record_bits),
        .done_valid(done_valid), .done_ready(done_ready),
        .done_addr(done_addr), .done_bits(done_bits), .done_cycle(done_cycle),
        .starve_cycles(starve_cycles), .bad_desc(bad_desc)
    );

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
    } pair_t;

    pair_t exp_upd[$];
    pair_t exp_done[$];

    int          n_checks = 0;
    int          n_pass = 0;
    int unsigned cyc = 0;
    int unsigned upd_seen = 0;
    int unsigned done_seen = 0;
    int unsigned last_upd_cyc = 0;
    int unsigned post_cyc = 0;
    logic [31:0] starve_at_pop = '0;
    logic [63:0] last_done_cycle = '0;
    int          w_beats = 2;
    int          w_bpb = 100;
    int          w_cnt = 0;
    bit          w_armed = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic check_range(input string name, input logic [63:0] act,
                               input logic [63:0] lo, input logic [63:0] hi);
        n_checks++;
        if (act >= lo && act <= hi) n_pass++;
        else $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    endtask

    task automatic fail(input string name, input string why);
        n_checks++;
        $display("FAIL %s: %s", name, why);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Writer model: counts beats after each window load, then holds the exhausted flag.
    always @(negedge clk) begin
        if (rst) begin
            w_armed = 1'b0; w_cnt = 0; write_interrupt = 1'b0; record_bits = '0;
        end else if (write_buf_update) begin
            w_armed = 1'b1; w_cnt = 0; write_interrupt = 1'b0; record_bits = '0;
        end else if (w_armed && !write_interrupt) begin
            w_cnt++;
            record_bits = record_bits + 64'(w_bpb);
            if (w_cnt >= w_beats) write_interrupt = 1'b1;
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents an update or a completion.
    always @(negedge clk) begin
        pair_t e;
        if (!rst && write_buf_update) begin
            upd_seen++;
            last_upd_cyc = cyc;
            if (exp_upd.size() == 0) begin
                fail("upd_unexpected", $sformatf("addr 0x%0h with none queued", write_buf_addr));
            end else begin
                e = exp_upd.pop_front();
                check("upd_addr", write_buf_addr, e.a);
                check("upd_size", write_buf_size, e.b);
            end
        end
        if (done_valid && done_ready) begin
            done_seen++;
            starve_at_pop = starve_cycles;
            last_done_cycle = done_cycle;
            if (exp_done.size() == 0) begin
                fail("done_unexpected", $sformatf("addr 0x%0h with none queued", done_addr));
            end else begin
                e = exp_done.pop_front();
                check("done_addr", done_addr, e.a);
                check("done_bits", done_bits, e.b);
`ifndef RR_BUFSEQ_TIMESTAMP_EN
                check("done_cycle_zero", done_cycle, 64'd0);
`endif
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic post(input logic [63:0] a, input logic [63:0] s, input bit ok);
        int t = 0;
        pair_t e;
        desc_valid = 1'b1; desc_addr = a; desc_size = s;
        while (!desc_ready && t < 300) begin tick(1); t++; end
        if (!desc_ready) fail("post_timeout", $sformatf("desc_ready low, addr 0x%0h", a));
        post_cyc = cyc;
        if (ok) begin
            e.a = a; e.b = s;                     exp_upd.push_back(e);
            e.b = 64'(w_beats) * 64'(w_bpb);      exp_done.push_back(e);
        end
        tick(1);
        desc_valid = 1'b0;
    endtask

    task automatic wait_upd(input int unsigned target, input string name);
        int t = 0;
        while (upd_seen < target && t < 500) begin tick(1); t++; end
        if (upd_seen < target) fail(name, "timeout waiting for update");
    endtask

    task automatic wait_done_empty(input string name);
        int t = 0;
        while (exp_done.size() != 0 && t < 1000) begin tick(1); t++; end
        if (exp_done.size() != 0) fail(name, $sformatf("timeout, %0d records missing", exp_done.size()));
    endtask

    initial begin
        int unsigned u0, d0;
        logic [31:0] s0;
        int t;

        // Reset state
        tick(1);
        check("rst_desc_ready", desc_ready, 0);
        rst = 1'b0;
        check("rst_buf_addr", write_buf_addr, 0);
        check("rst_buf_size", write_buf_size, 0);
        check("rst_update", write_buf_update, 0);
        check("rst_done_valid", done_valid, 0);
        check("rst_done_addr", done_addr, 0);
        check("rst_starve", starve_cycles, 0);
        check("rst_bad_desc", bad_desc, 0);
        tick(1);
        check("rst_desc_ready_after", desc_ready, 1);

        // Three back-to-back buffers, 2 beats each
        w_beats = 2; w_bpb = 100;
        post(64'h4000, 64'h40, 1);
        post(64'h5000, 64'h80, 1);
        post(64'h6000, 64'hC0, 1);
        wait_done_empty("t2_done");
        check("t2_upd_count", upd_seen, 3);
        check("t2_starve", starve_at_pop, 0);

        // Single buffer, 4 beats x 450 bits = 1800
        w_beats = 4; w_bpb = 450;
        post(64'h1000, 64'h100, 1);
        wait_done_empty("t1_done");
        check("t1_upd_count", upd_seen, 4);

        // Bad descriptors dropped
        u0 = upd_seen;
        post(64'h2000, 64'h30, 0);
        post(64'h3000, 64'h0, 0);
        tick(10);
        check("t3_bad_desc", bad_desc, 1);
        check("t3_desc_ready", desc_ready, 1);
        check("t3_no_update", upd_seen, u0);

        // Starvation count while the writer stays exhausted, then update latency
        w_beats = 4; w_bpb = 10;
        u0 = upd_seen;
        post(64'h7000, 64'h40, 1);
        wait_upd(u0 + 1, "t5_upd");
        t = 0;
        while (!write_interrupt && t < 100) begin tick(1); t++; end
        if (!write_interrupt) fail("t5_intr", "writer never exhausted");
        s0 = starve_cycles;
        tick(9);
        check_range("t5_starve", 64'(starve_cycles - s0), 8, 10);
        u0 = upd_seen;
        post(64'h8000, 64'h40, 1);
        wait_upd(u0 + 1, "t5_upd2");
        check("t5_latency", 64'(last_upd_cyc - post_cyc), 2);
        wait_done_empty("t5_done");

        // Completion queue back-pressure: 5 buffers into a 4-deep queue
        done_ready = 1'b0;
        w_beats = 2; w_bpb = 100;
        u0 = upd_seen; d0 = done_seen;
        for (int i = 0; i < 5; i++) post(64'h9000 + 64'(i) * 64'h1000, 64'h40, 1);
        wait_upd(u0 + 5, "t4_upd");
        tick(20);
        check("t4_upd_count", upd_seen - u0, 5);
        check("t4_no_pop", done_seen - d0, 0);
        check("t4_done_valid", done_valid, 1);
        done_ready = 1'b1;
        wait_done_empty("t4_done");
        check("t4_done_count", done_seen - d0, 5);

        // Reset mid-operation with two descriptors still queued
        w_beats = 50;
        u0 = upd_seen;
        post(64'hE000, 64'h40, 1);
        post(64'hF000, 64'h40, 1);
        post(64'h10000, 64'h40, 1);
        wait_upd(u0 + 1, "t6_upd");
        tick(8);
        rst = 1'b1;
        exp_upd.delete();
        exp_done.delete();
        tick(1);
        check("t6_desc_ready_rst", desc_ready, 0);
        check("t6_buf_addr", write_buf_addr, 0);
        check("t6_done_valid", done_valid, 0);
        check("t6_starve", starve_cycles, 0);
        check("t6_bad_desc", bad_desc, 0);
        rst = 1'b0;
        u0 = upd_seen;
        tick(1);
        check("t6_desc_ready_after", desc_ready, 1);
        tick(10);
        check("t6_no_update", upd_seen, u0);
        w_beats = 2; w_bpb = 100;
        post(64'h11000, 64'h40, 1);
        wait_done_empty("t6_done");
        check("t6_upd_count", upd_seen - u0, 1);
`ifdef RR_BUFSEQ_TIMESTAMP_EN
        check_range("t6_done_cycle", last_done_cycle, 1, 40);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
